// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch front end. Owns the fetch PC and issues one word request at
// a time to instruction memory. Each returned word is buffered with its PC+4 in
// a small FIFO. The FIFO head feeds the IF/ID pipeline register inputs.
//
// Handshakes:
//   - A request transfers on a rising clk edge where imem_req & imem_ready.
//     imem_req only depends on registered state, redirect and clrn. imem_addr
//     holds steady for as long as imem_req is held.
//   - Memory returns exactly one imem_rvalid pulse per accepted request. The
//     pulses arrive in order, at least one cycle after acceptance.
//   - The IF/ID side consumes the head entry on a rising edge where
//     if_valid & !stall & !redirect.
//
// Ports:
//   clk, clrn            clock / asynchronous active-low reset
//   stall                IF/ID holds; head entry is not consumed
//   redirect/redirect_pc flush the fetch path and restart at redirect_pc
//   imem_req/imem_addr   request to instruction memory (word aligned)
//   imem_ready           memory accepts the request
//   imem_rvalid/rdata    response from instruction memory
//   if_inst/if_pc4       FIFO head (zeros when empty, i.e. a NOP bubble)
//   if_valid             FIFO non-empty
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc4,
    output logic        if_valid
);

    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   inst_buf [FIFO_DEPTH];
    logic [31:0]   pc4_buf  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          outstanding;
    logic          discard;

    logic          buf_empty;
    logic          buf_full;
    logic          accept;
    logic          resp;
    logic          push;
    logic          pop;

    assign buf_empty = (count == '0);
    assign buf_full  = (count == DEPTH_C);

    // A request is only raised when the FIFO has room for its reply. With a
    // single outstanding request this is enough to make overflow impossible.
    // Gating with clrn keeps the request low while reset is held.
    assign imem_req  = clrn && !outstanding && !buf_full && !redirect;
    assign imem_addr = fetch_pc;

    assign accept = imem_req && imem_ready;
    assign resp   = imem_rvalid && outstanding;
    // A reply is dropped when it belongs to a flushed path (discard) or when it
    // arrives in the same cycle as a redirect.
    assign push   = resp && !discard && !redirect;
    assign pop    = !stall && !buf_empty && !redirect;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            if (resp) begin
                outstanding <= 1'b0;
            end else if (accept) begin
                outstanding <= 1'b1;
            end

            if (accept) begin
                req_pc <= fetch_pc;
            end

            // A redirect that leaves a reply in flight marks that reply as
            // stale. Any reply clears the mark, because only one can be pending.
            if (resp) begin
                discard <= 1'b0;
            end else if (redirect && outstanding) begin
                discard <= 1'b1;
            end

            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'h3;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Buffer storage needs no reset. The outputs are masked while the FIFO is
    // empty, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_buf[wr_ptr] <= imem_rdata;
            pc4_buf[wr_ptr]  <= req_pc + 32'd4;
        end
    end

    assign if_valid = !buf_empty;
    assign if_inst  = buf_empty ? 32'h0 : inst_buf[rd_ptr];
    assign if_pc4   = buf_empty ? 32'h0 : pc4_buf[rd_ptr];

endmodule
